// File: rtl/redirect_ctrl_pkg.sv
// Shared definitions for the redirect/flush sequencer.
package redirect_ctrl_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned FLUSH_W = 4;

    // Low PC bits that must be zero for a 4-byte aligned target
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_BR   = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_TRAP = 2'd2
    } src_t;

endpackage

// File: rtl/redirect_sel.sv
// Fixed-priority redirect source select (trap > jump > branch) with target alignment check.
module redirect_sel
    import redirect_ctrl_pkg::*;
(
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            trap_valid,
    input  logic [PC_W-1:0] trap_vector,
    output logic            sel_valid,
    output logic [PC_W-1:0] sel_pc,
    output logic            sel_misalign
);

    src_t src;
    logic any_req;
    logic bad_align;

    // Pick the winning source and its target; lower-priority requests are dropped
    always_comb begin
        src     = SRC_BR;
        sel_pc  = br_target;
        any_req = br_taken | jmp_valid | trap_valid;
        if (trap_valid) begin
            src    = SRC_TRAP;
            sel_pc = trap_vector;
        end else if (jmp_valid) begin
            src    = SRC_JMP;
            sel_pc = jmp_target & ~PC_W'(1);
        end
    end

    // Trap vectors are trusted; branch/jump targets must be word aligned
    always_comb begin
        bad_align    = (src != SRC_TRAP) && ((sel_pc & PC_ALIGN_MASK) != '0);
        sel_misalign = any_req & bad_align;
        sel_valid    = any_req & ~bad_align;
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect and flush sequencer: offers the selected target PC to fetch, then squashes wrong-path bubbles.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             jmp_valid,
    input  logic [PC_W-1:0]  jmp_target,
    input  logic             trap_valid,
    input  logic [PC_W-1:0]  trap_vector,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             ignore_curr_inst,
    output logic             misalign_exc,
    output logic             busy,
    output logic [CNT_W-1:0] redirect_count
);

    state_t             state;
    logic [FLUSH_W-1:0] flush_cnt;

    logic               sel_valid;
    logic [PC_W-1:0]    sel_pc;
    logic               sel_misalign;

    redirect_sel u_sel (
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .trap_valid   (trap_valid),
        .trap_vector  (trap_vector),
        .sel_valid    (sel_valid),
        .sel_pc       (sel_pc),
        .sel_misalign (sel_misalign)
    );

    // Sequencer FSM with registered outputs, flush countdown and accepted-redirect counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            ignore_curr_inst <= 1'b0;
            misalign_exc     <= 1'b0;
            busy             <= 1'b0;
            redirect_count   <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state            <= REQ;
                        redirect_pc      <= sel_pc;
                        redirect_valid   <= 1'b1;
                        ignore_curr_inst <= 1'b1;
                        busy             <= 1'b1;
                    end else if (sel_misalign) begin
                        misalign_exc <= 1'b1;
                    end
                end
                REQ: begin
                    // A handshake wins over a same-cycle trap; the trap retries later if still held
                    if (fetch_ready) begin
                        state          <= FLUSH;
                        redirect_valid <= 1'b0;
                        redirect_count <= redirect_count + CNT_W'(1);
                        flush_cnt      <= FLUSH_W'(FLUSH_CYCLES);
                    end else if (trap_valid) begin
                        redirect_pc <= trap_vector;
                    end
                end
                FLUSH: begin
                    if (trap_valid) begin
                        state          <= REQ;
                        redirect_pc    <= trap_vector;
                        redirect_valid <= 1'b1;
                        flush_cnt      <= '0;
                    end else if (!stall) begin
                        flush_cnt <= flush_cnt - FLUSH_W'(1);
                        if (flush_cnt == FLUSH_W'(1)) begin
                            state            <= IDLE;
                            ignore_curr_inst <= 1'b0;
                            busy             <= 1'b0;
                        end
                    end
                end
                default: begin
                    state            <= IDLE;
                    redirect_valid   <= 1'b0;
                    ignore_curr_inst <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl (FLUSH_CYCLES=2, CNT_W=2 so the counter wrap is reachable).
module tb_redirect_ctrl;

    localparam int unsigned CNT_W = 2;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             jmp_valid;
    logic [31:0]      jmp_target;
    logic             trap_valid;
    logic [31:0]      trap_vector;
    logic             stall;
    logic             fetch_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             ignore_curr_inst;
    logic             misalign_exc;
    logic             busy;
    logic [CNT_W-1:0] redirect_count;

    int n_chk  = 0;
    int n_fail = 0;

    redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .trap_valid       (trap_valid),
        .trap_vector      (trap_vector),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .ignore_curr_inst (ignore_curr_inst),
        .misalign_exc     (misalign_exc),
        .busy             (busy),
        .redirect_count   (redirect_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic ign, input logic bsy);
        chk({tag, ".valid"},  32'(redirect_valid),   32'(v));
        chk({tag, ".ignore"}, 32'(ignore_curr_inst), 32'(ign));
        chk({tag, ".busy"},   32'(busy),             32'(bsy));
    endtask

    initial begin
        i_rst = 1'b0; br_taken = 1'b0; br_target = '0; jmp_valid = 1'b0; jmp_target = '0;
        trap_valid = 1'b0; trap_vector = '0; stall = 1'b0; fetch_ready = 1'b0;

        // Reset state
        #12;
        chk_state("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.pc", redirect_pc, 32'h0);
        chk("rst.misalign", 32'(misalign_exc), 32'h0);
        chk("rst.count", 32'(redirect_count), 32'h0);
        i_rst = 1'b1;
        tick();

        // Branch with immediate handshake
        br_taken = 1'b1; br_target = 32'h100; fetch_ready = 1'b1;
        tick();
        br_taken = 1'b0;
        chk_state("br.c1", 1'b1, 1'b1, 1'b1);
        chk("br.c1.pc", redirect_pc, 32'h100);
        tick();
        chk_state("br.c2", 1'b0, 1'b1, 1'b1);
        chk("br.c2.count", 32'(redirect_count), 32'h1);
        tick();
        chk_state("br.c3", 1'b0, 1'b1, 1'b1);
        tick();
        chk_state("br.c4", 1'b0, 1'b0, 1'b0);
        chk("br.c4.count", 32'(redirect_count), 32'h1);

        // Jump with delayed handshake and stalled flush
        fetch_ready = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h205;
        tick();
        jmp_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk_state($sformatf("jmp.req%0d", i), 1'b1, 1'b1, 1'b1);
            chk($sformatf("jmp.req%0d.pc", i), redirect_pc, 32'h204);
            tick();
        end
        chk_state("jmp.req4", 1'b1, 1'b1, 1'b1);
        chk("jmp.req4.pc", redirect_pc, 32'h204);
        fetch_ready = 1'b1;
        tick();
        stall = 1'b1;
        chk_state("jmp.fl1", 1'b0, 1'b1, 1'b1);
        chk("jmp.fl1.count", 32'(redirect_count), 32'h2);
        tick();
        chk_state("jmp.fl2", 1'b0, 1'b1, 1'b1);
        tick();
        stall = 1'b0;
        chk_state("jmp.fl3", 1'b0, 1'b1, 1'b1);
        tick();
        chk_state("jmp.fl4", 1'b0, 1'b1, 1'b1);
        tick();
        chk_state("jmp.idle", 1'b0, 1'b0, 1'b0);

        // Misaligned branch: one-cycle exception pulse, no redirect
        br_taken = 1'b1; br_target = 32'h102;
        tick();
        br_taken = 1'b0;
        chk("mis.br.pulse", 32'(misalign_exc), 32'h1);
        chk_state("mis.br", 1'b0, 1'b0, 1'b0);
        tick();
        chk("mis.br.clear", 32'(misalign_exc), 32'h0);
        chk("mis.br.count", 32'(redirect_count), 32'h2);

        // Misaligned jump (bit1 set survives the bit0 clear)
        jmp_valid = 1'b1; jmp_target = 32'h203;
        tick();
        jmp_valid = 1'b0;
        chk("mis.jmp.pulse", 32'(misalign_exc), 32'h1);
        chk("mis.jmp.busy", 32'(busy), 32'h0);
        tick();

        // Simultaneous requests: trap wins, one count only
        br_taken = 1'b1; br_target = 32'h300; jmp_valid = 1'b1; jmp_target = 32'h400;
        trap_valid = 1'b1; trap_vector = 32'h8000_0000;
        tick();
        br_taken = 1'b0; jmp_valid = 1'b0; trap_valid = 1'b0;
        chk("sim.pc", redirect_pc, 32'h8000_0000);
        chk("sim.valid", 32'(redirect_valid), 32'h1);
        tick();
        tick();
        tick();
        chk_state("sim.idle", 1'b0, 1'b0, 1'b0);
        chk("sim.count", 32'(redirect_count), 32'h3);

        // Fourth accepted redirect wraps the 2-bit counter; then wrong-path and trap preemption in FLUSH
        br_taken = 1'b1; br_target = 32'h500;
        tick();
        br_taken = 1'b0;
        tick();
        chk("wrap.count", 32'(redirect_count), 32'h0);
        br_taken = 1'b1; br_target = 32'h600;
        tick();
        br_taken = 1'b0;
        chk_state("wp.flush", 1'b0, 1'b1, 1'b1);
        chk("wp.pc", redirect_pc, 32'h500);
        trap_valid = 1'b1; trap_vector = 32'h40; fetch_ready = 1'b0;
        tick();
        trap_valid = 1'b0;
        chk_state("trapfl.req", 1'b1, 1'b1, 1'b1);
        chk("trapfl.pc", redirect_pc, 32'h40);

        // Trap preemption inside REQ without handshake
        trap_valid = 1'b1; trap_vector = 32'h80;
        tick();
        trap_valid = 1'b0;
        chk("trapreq.pc", redirect_pc, 32'h80);
        chk("trapreq.valid", 32'(redirect_valid), 32'h1);
        chk("trapreq.count", 32'(redirect_count), 32'h0);

        // Asynchronous reset during REQ
        i_rst = 1'b0;
        #1;
        chk_state("arst", 1'b0, 1'b0, 1'b0);
        chk("arst.pc", redirect_pc, 32'h0);
        chk("arst.count", 32'(redirect_count), 32'h0);
        chk("arst.misalign", 32'(misalign_exc), 32'h0);
        i_rst = 1'b1;
        tick();
        chk_state("arst.after", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
